// File: rtl/lcd_pkg.sv
// Shared types, command bytes, default timing and message ROM for the
// HD44780 4-bit write-only LCD controller.
package lcd_pkg;

    typedef enum logic [3:0] {
        POWERUP    = 4'd0,
        INIT_A     = 4'd1,
        INIT_B     = 4'd2,
        INIT_C     = 4'd3,
        INIT_D     = 4'd4,
        FUNC_SET   = 4'd5,
        ENTRY_MODE = 4'd6,
        DISPLAY_ON = 4'd7,
        CLEAR      = 4'd8,
        SET_ADDR   = 4'd9,
        WRITE_CHAR = 4'd10,
        DONE       = 4'd11
    } lcdState_t;

    typedef enum logic [1:0] {
        PH_WAIT   = 2'd0,
        PH_NIBBLE = 2'd1,
        PH_IDLE   = 2'd2
    } lcdPhase_t;

    typedef enum logic [2:0] {
        WR_IDLE  = 3'd0,
        WR_SETUP = 3'd1,
        WR_PULSE = 3'd2,
        WR_HOLD  = 3'd3,
        WR_DONE  = 3'd4
    } wrState_t;

    localparam int unsigned CNT_W = 24;

    localparam logic [7:0] CMD_FUNC_SET   = 8'h28;
    localparam logic [7:0] CMD_ENTRY_MODE = 8'h06;
    localparam logic [7:0] CMD_DISPLAY_ON = 8'h0C;
    localparam logic [7:0] CMD_CLEAR      = 8'h01;
    localparam logic [7:0] CMD_SET_ADDR   = 8'h80;

    // Init steps send only the upper nibble, so they sit in bits [7:4].
    localparam logic [7:0] INIT_NIB_3 = 8'h30;
    localparam logic [7:0] INIT_NIB_2 = 8'h20;

    localparam int unsigned DEF_T_POWERUP = 750000;
    localparam int unsigned DEF_T_INIT1   = 205000;
    localparam int unsigned DEF_T_INIT2   = 5000;
    localparam int unsigned DEF_T_CMD     = 2000;
    localparam int unsigned DEF_T_CLEAR   = 82000;
    localparam int unsigned DEF_T_NIBGAP  = 50;
    localparam int unsigned DEF_T_SETUP   = 2;
    localparam int unsigned DEF_T_PULSE   = 12;
    localparam int unsigned DEF_T_HOLD    = 1;

    localparam int unsigned MSG_LEN = 12;

    function automatic logic [7:0] msgChar(input logic [3:0] idx);
        logic [7:0] c;
        case (idx)
            4'd0:    c = 8'h48;
            4'd1:    c = 8'h65;
            4'd2:    c = 8'h6C;
            4'd3:    c = 8'h6C;
            4'd4:    c = 8'h6F;
            4'd5:    c = 8'h20;
            4'd6:    c = 8'h57;
            4'd7:    c = 8'h6F;
            4'd8:    c = 8'h72;
            4'd9:    c = 8'h6C;
            4'd10:   c = 8'h64;
            4'd11:   c = 8'h21;
            default: c = 8'h20;
        endcase
        return c;
    endfunction

    function automatic logic [7:0] stepByte(input lcdState_t s, input logic [3:0] idx);
        logic [7:0] b;
        case (s)
            INIT_A, INIT_B, INIT_C: b = INIT_NIB_3;
            INIT_D:                 b = INIT_NIB_2;
            FUNC_SET:               b = CMD_FUNC_SET;
            ENTRY_MODE:             b = CMD_ENTRY_MODE;
            DISPLAY_ON:             b = CMD_DISPLAY_ON;
            CLEAR:                  b = CMD_CLEAR;
            SET_ADDR:               b = CMD_SET_ADDR;
            WRITE_CHAR:             b = msgChar(idx);
            default:                b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic isByteStep(input lcdState_t s);
        return (s >= FUNC_SET) && (s <= WRITE_CHAR);
    endfunction

    function automatic lcdState_t nextStep(input lcdState_t s);
        lcdState_t n;
        case (s)
            POWERUP:    n = INIT_A;
            INIT_A:     n = INIT_B;
            INIT_B:     n = INIT_C;
            INIT_C:     n = INIT_D;
            INIT_D:     n = FUNC_SET;
            FUNC_SET:   n = ENTRY_MODE;
            ENTRY_MODE: n = DISPLAY_ON;
            DISPLAY_ON: n = CLEAR;
            CLEAR:      n = SET_ADDR;
            SET_ADDR:   n = WRITE_CHAR;
            WRITE_CHAR: n = WRITE_CHAR;
            default:    n = DONE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/lcd_nibble_writer.sv
// Writes one nibble to the LCD bus: setup, E pulse, hold, then a one-cycle done.
module lcd_nibble_writer
    import lcd_pkg::*;
#(
    parameter int unsigned T_SETUP = DEF_T_SETUP,
    parameter int unsigned T_PULSE = DEF_T_PULSE,
    parameter int unsigned T_HOLD  = DEF_T_HOLD
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       start,
    input  logic [3:0] nibble,
    input  logic       rs,
    output logic       done,
    output logic       lcdE,
    output logic [3:0] lcdData,
    output logic       lcdRs
);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(T_HOLD - 1);

    wrState_t         st;
    logic [CNT_W-1:0] cnt;

    assign done = (st == WR_DONE);

    // Data/RS are loaded only from idle and cleared only after the hold,
    // so they are frozen for the whole time E is high.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            st      <= WR_IDLE;
            cnt     <= '0;
            lcdE    <= 1'b0;
            lcdData <= '0;
            lcdRs   <= 1'b0;
        end else begin
            case (st)
                WR_IDLE: begin
                    if (start) begin
                        lcdData <= nibble;
                        lcdRs   <= rs;
                        cnt     <= '0;
                        st      <= WR_SETUP;
                    end
                end
                WR_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt  <= '0;
                        lcdE <= 1'b1;
                        st   <= WR_PULSE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WR_PULSE: begin
                    if (cnt == PULSE_LAST) begin
                        cnt  <= '0;
                        lcdE <= 1'b0;
                        st   <= WR_HOLD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WR_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt <= '0;
                        st  <= WR_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WR_DONE: begin
                    lcdData <= '0;
                    lcdRs   <= 1'b0;
                    st      <= WR_IDLE;
                end
                default: begin
                    lcdE <= 1'b0;
                    st   <= WR_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/module_lcd_control.sv
// HD44780 4-bit LCD controller: power-on init, display setup, then writes
// "Hello World!" at line 1 column 0 and idles.
module module_lcd_control
    import lcd_pkg::*;
#(
    parameter int unsigned T_POWERUP = DEF_T_POWERUP,
    parameter int unsigned T_INIT1   = DEF_T_INIT1,
    parameter int unsigned T_INIT2   = DEF_T_INIT2,
    parameter int unsigned T_CMD     = DEF_T_CMD,
    parameter int unsigned T_CLEAR   = DEF_T_CLEAR,
    parameter int unsigned T_NIBGAP  = DEF_T_NIBGAP,
    parameter int unsigned T_SETUP   = DEF_T_SETUP,
    parameter int unsigned T_PULSE   = DEF_T_PULSE,
    parameter int unsigned T_HOLD    = DEF_T_HOLD
) (
    input  logic       Clock,
    input  logic       Reset,
    output logic       oLCD_Enabled,
    output logic       oLCD_RegisterSelect,
    output logic       oLCD_StrataFlashControl,
    output logic       oLCD_ReadWrite,
    output logic [3:0] oLCD_Data
);

    localparam logic [CNT_W-1:0] POWERUP_LAST = CNT_W'(T_POWERUP - 1);
    localparam logic [CNT_W-1:0] INIT1_LAST   = CNT_W'(T_INIT1 - 1);
    localparam logic [CNT_W-1:0] INIT2_LAST   = CNT_W'(T_INIT2 - 1);
    localparam logic [CNT_W-1:0] CMD_LAST     = CNT_W'(T_CMD - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST   = CNT_W'(T_CLEAR - 1);
    localparam logic [CNT_W-1:0] NIBGAP_LAST  = CNT_W'(T_NIBGAP - 1);

    lcdState_t        state;
    lcdPhase_t        phase;
    logic [CNT_W-1:0] waitCnt;
    logic [CNT_W-1:0] waitLast;
    logic [CNT_W-1:0] postLast;
    logic             lowPending;
    logic [3:0]       idx;

    lcdState_t        launchState;
    logic [3:0]       launchIdx;
    logic             launchLow;
    logic             launch;
    logic             waitDone;
    logic [7:0]       launchByte;
    logic [3:0]       launchNibble;
    logic             launchRs;
    logic             wrDone;

    assign oLCD_StrataFlashControl = 1'b1;
    assign oLCD_ReadWrite          = 1'b0;

    // The next nibble is launched in the last cycle of a wait, so the writer's
    // setup starts exactly when the wait expires rather than one cycle later.
    always_comb begin
        waitDone    = (phase == PH_WAIT) && (waitCnt == waitLast);
        launchState = state;
        launchIdx   = idx;
        launchLow   = 1'b0;
        launch      = 1'b0;
        if (waitDone) begin
            if (lowPending) begin
                launch    = 1'b1;
                launchLow = 1'b1;
            end else begin
                if (state == WRITE_CHAR) begin
                    if (idx == 4'(MSG_LEN - 1)) begin
                        launchState = DONE;
                    end else begin
                        launchIdx = idx + 4'd1;
                    end
                end else begin
                    launchState = nextStep(state);
                end
                launch = (launchState != DONE);
            end
        end
        launchByte   = stepByte(launchState, launchIdx);
        launchNibble = launchLow ? launchByte[3:0] : launchByte[7:4];
        launchRs     = (launchState == WRITE_CHAR);
    end

    always_comb begin
        case (state)
            INIT_A:  postLast = INIT1_LAST;
            INIT_B:  postLast = INIT2_LAST;
            CLEAR:   postLast = CLEAR_LAST;
            default: postLast = CMD_LAST;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= POWERUP;
            phase      <= PH_WAIT;
            waitCnt    <= '0;
            waitLast   <= POWERUP_LAST;
            lowPending <= 1'b0;
            idx        <= '0;
        end else begin
            case (phase)
                PH_WAIT: begin
                    if (waitDone) begin
                        waitCnt <= '0;
                        state   <= launchState;
                        idx     <= launchIdx;
                        phase   <= launch ? PH_NIBBLE : PH_IDLE;
                    end else begin
                        waitCnt <= waitCnt + CNT_W'(1);
                    end
                end
                PH_NIBBLE: begin
                    if (wrDone) begin
                        phase   <= PH_WAIT;
                        waitCnt <= '0;
                        if (isByteStep(state) && !lowPending) begin
                            waitLast   <= NIBGAP_LAST;
                            lowPending <= 1'b1;
                        end else begin
                            waitLast   <= postLast;
                            lowPending <= 1'b0;
                        end
                    end
                end
                PH_IDLE: begin
                    phase <= PH_IDLE;
                end
                default: begin
                    phase <= PH_IDLE;
                end
            endcase
        end
    end

    lcd_nibble_writer #(
        .T_SETUP(T_SETUP),
        .T_PULSE(T_PULSE),
        .T_HOLD (T_HOLD)
    ) uWriter (
        .clk    (Clock),
        .rstN   (Reset),
        .start  (launch),
        .nibble (launchNibble),
        .rs     (launchRs),
        .done   (wrDone),
        .lcdE   (oLCD_Enabled),
        .lcdData(oLCD_Data),
        .lcdRs  (oLCD_RegisterSelect)
    );

endmodule

// File: tb/tb_module_lcd_control.sv
// Scoreboard bench for module_lcd_control with scaled-down timing.
module tb_module_lcd_control;

    localparam int unsigned P_POWERUP = 100;
    localparam int unsigned P_INIT1   = 60;
    localparam int unsigned P_INIT2   = 30;
    localparam int unsigned P_CMD     = 20;
    localparam int unsigned P_CLEAR   = 50;
    localparam int unsigned P_NIBGAP  = 5;
    localparam int unsigned P_SETUP   = 2;
    localparam int unsigned P_PULSE   = 12;
    localparam int unsigned P_HOLD    = 1;

    typedef struct {
        logic [3:0]  nib;
        logic        rs;
        int unsigned gap;
    } expPulse_t;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       oLCD_Enabled;
    logic       oLCD_RegisterSelect;
    logic       oLCD_StrataFlashControl;
    logic       oLCD_ReadWrite;
    logic [3:0] oLCD_Data;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;

    expPulse_t   expQ[$];
    int unsigned riseCnt    = 0;
    int unsigned unexpected = 0;
    int unsigned lowCnt     = 0;
    int unsigned highCnt    = 0;
    logic        lastE      = 1'b0;
    logic        stableBad  = 1'b0;
    logic [3:0]  holdData   = '0;
    logic        holdRs     = 1'b0;

    module_lcd_control #(
        .T_POWERUP(P_POWERUP),
        .T_INIT1  (P_INIT1),
        .T_INIT2  (P_INIT2),
        .T_CMD    (P_CMD),
        .T_CLEAR  (P_CLEAR),
        .T_NIBGAP (P_NIBGAP),
        .T_SETUP  (P_SETUP),
        .T_PULSE  (P_PULSE),
        .T_HOLD   (P_HOLD)
    ) dut (
        .Clock                  (Clock),
        .Reset                  (Reset),
        .oLCD_Enabled           (oLCD_Enabled),
        .oLCD_RegisterSelect    (oLCD_RegisterSelect),
        .oLCD_StrataFlashControl(oLCD_StrataFlashControl),
        .oLCD_ReadWrite         (oLCD_ReadWrite),
        .oLCD_Data              (oLCD_Data)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Low time before a pulse that follows a wait of w cycles:
    // hold + one done cycle + the wait + setup.
    function automatic int unsigned gapAfter(input int unsigned w);
        return P_HOLD + 1 + w + P_SETUP;
    endfunction

    task automatic pushNib(input logic [3:0] nib, input logic rs, input int unsigned gap);
        expPulse_t e;
        e.nib = nib;
        e.rs  = rs;
        e.gap = gap;
        expQ.push_back(e);
    endtask

    task automatic pushByte(input logic [7:0] b, input logic rs, input int unsigned prevWait);
        pushNib(b[7:4], rs, gapAfter(prevWait));
        pushNib(b[3:0], rs, gapAfter(P_NIBGAP));
    endtask

    task automatic pushInit();
        pushNib(4'h3, 1'b0, P_POWERUP + P_SETUP);
        pushNib(4'h3, 1'b0, gapAfter(P_INIT1));
        pushNib(4'h3, 1'b0, gapAfter(P_INIT2));
        pushNib(4'h2, 1'b0, gapAfter(P_CMD));
    endtask

    task automatic pushAll();
        string      msg;
        logic [7:0] ch;
        msg = "Hello World!";
        pushInit();
        pushByte(8'h28, 1'b0, P_CMD);
        pushByte(8'h06, 1'b0, P_CMD);
        pushByte(8'h0C, 1'b0, P_CMD);
        pushByte(8'h01, 1'b0, P_CMD);
        pushByte(8'h80, 1'b0, P_CLEAR);
        for (int i = 0; i < msg.len(); i++) begin
            ch = msg[i];
            pushByte(ch, 1'b1, P_CMD);
        end
    endtask

    // Bus monitor: pops the scoreboard on every E rise, checks width and stability.
    always @(negedge Clock) begin
        chk("rw_low", 32'(oLCD_ReadWrite), 32'd0);
        chk("sf_high", 32'(oLCD_StrataFlashControl), 32'd1);
        if (!Reset) begin
            lastE   = 1'b0;
            lowCnt  = 0;
            highCnt = 0;
        end else begin
            if (oLCD_Enabled && !lastE) begin
                riseCnt++;
                if (expQ.size() == 0) begin
                    unexpected++;
                end else begin
                    expPulse_t e;
                    e = expQ.pop_front();
                    chk("nibble", 32'(oLCD_Data), 32'(e.nib));
                    chk("rs", 32'(oLCD_RegisterSelect), 32'(e.rs));
                    chk("gap", 32'(lowCnt), 32'(e.gap));
                end
                holdData  = oLCD_Data;
                holdRs    = oLCD_RegisterSelect;
                highCnt   = 1;
                stableBad = 1'b0;
            end else if (oLCD_Enabled) begin
                highCnt++;
                if (oLCD_Data !== holdData || oLCD_RegisterSelect !== holdRs)
                    stableBad = 1'b1;
            end else if (lastE) begin
                chk("e_width", 32'(highCnt), 32'(P_PULSE));
                chk("stable_while_e", 32'(stableBad), 32'd0);
                lowCnt = 1;
            end else begin
                lowCnt++;
            end
            lastE = oLCD_Enabled;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base;
        int unsigned target;

        repeat (5) begin
            @(negedge Clock);
            chk("rst_e", 32'(oLCD_Enabled), 32'd0);
            chk("rst_rs", 32'(oLCD_RegisterSelect), 32'd0);
            chk("rst_data", 32'(oLCD_Data), 32'd0);
        end
        chk("rst_no_pulse", 32'(riseCnt), 32'd0);

        pushAll();
        @(posedge Clock);
        #2 Reset = 1'b1;
        for (int c = 0; c < 20000 && expQ.size() != 0; c++) @(negedge Clock);
        chk("sequence_drained", 32'(expQ.size()), 32'd0);

        repeat (50) @(negedge Clock);
        base = riseCnt;
        repeat (10000) @(negedge Clock);
        chk("quiet_after_done", 32'(riseCnt), 32'(base));
        chk("done_e", 32'(oLCD_Enabled), 32'd0);
        chk("done_rs", 32'(oLCD_RegisterSelect), 32'd0);
        chk("done_data", 32'(oLCD_Data), 32'd0);
        chk("unexpected_pulses", 32'(unexpected), 32'd0);

        // Second run: reset lands in the middle of the 5th character's first E pulse.
        @(posedge Clock);
        #2 Reset = 1'b0;
        repeat (3) @(negedge Clock);
        pushAll();
        base   = riseCnt;
        target = base + 23;
        @(posedge Clock);
        #2 Reset = 1'b1;
        for (int c = 0; c < 5000 && riseCnt < target; c++) @(negedge Clock);
        chk("reached_5th_char", 32'(riseCnt), 32'(target));
        chk("mid_pulse_e_high", 32'(oLCD_Enabled), 32'd1);
        @(posedge Clock);
        #3 Reset = 1'b0;
        #1 chk("async_e_drop", 32'(oLCD_Enabled), 32'd0);
        expQ.delete();
        base = riseCnt;
        repeat (5) begin
            @(negedge Clock);
            chk("rst2_e", 32'(oLCD_Enabled), 32'd0);
        end
        chk("rst2_no_pulse", 32'(riseCnt), 32'(base));

        pushInit();
        @(posedge Clock);
        #2 Reset = 1'b1;
        for (int c = 0; c < 3000 && expQ.size() != 0; c++) @(negedge Clock);
        chk("restart_drained", 32'(expQ.size()), 32'd0);
        repeat (30) @(negedge Clock);
        chk("unexpected_pulses_end", 32'(unexpected), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
